// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. A horizontal/vertical counter
//                pair (stage 0) drives the pixel coordinates handed to the
//                painters. Stage 1 registers the syncs and the blanked colour,
//                so hsync/vsync/rgb trail hpos/vpos by exactly one clock.
//  Ports       : clk         - pixel clock, rising edge
//                rst         - synchronous active-high reset
//                color_in    - BBGGRR colour for the current hpos/vpos
//                hpos        - horizontal counter (0 .. H_TOTAL-1)
//                vpos        - low 9 bits of the vertical counter
//                display_on  - stage-0 visible-region flag
//                frame_start - stage-0 pulse at hcount=0, vcount=0
//                hsync/vsync - active-low syncs, registered (stage 1)
//                rgb         - registered colour, zero outside visible area
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] color_in,
    output logic [9:0] hpos,
    output logic [8:0] vpos,
    output logic       display_on,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb
);

    // Totals must fit the 10-bit counters (800 and 525 for standard VGA).
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_ACTIVE     = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACTIVE     = 10'(V_ACTIVE);
    localparam logic [9:0] c_H_SYNC_FIRST = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] c_H_SYNC_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_V_SYNC_FIRST = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] c_V_SYNC_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    // Stage 0 counters
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;

    // Stage 1 registered outputs
    logic       r_hsync;
    logic       r_vsync;
    logic [5:0] r_rgb;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_display_on;
    logic       w_hsync_raw;
    logic       w_vsync_raw;

    assign w_h_last     = (r_hcount == c_H_LAST);
    assign w_v_last     = (r_vcount == c_V_LAST);
    assign w_display_on = (r_hcount < c_H_ACTIVE) && (r_vcount < c_V_ACTIVE);
    assign w_hsync_raw  = !((r_hcount >= c_H_SYNC_FIRST) && (r_hcount <= c_H_SYNC_LAST));
    assign w_vsync_raw  = !((r_vcount >= c_V_SYNC_FIRST) && (r_vcount <= c_V_SYNC_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_rgb    <= 6'd0;
        end else begin
            r_hcount <= w_h_last ? 10'd0 : r_hcount + 10'd1;
            // The vertical counter only moves on the horizontal wrap, so both
            // counters return to zero on the same edge at the frame boundary.
            if (w_h_last) begin
                r_vcount <= w_v_last ? 10'd0 : r_vcount + 10'd1;
            end
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
            r_rgb   <= w_display_on ? color_in : 6'd0;
        end
    end

    assign hpos        = r_hcount;
    assign vpos        = r_vcount[8:0];
    assign display_on  = w_display_on;
    assign frame_start = (r_hcount == 10'd0) && (r_vcount == 10'd0);
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Directed bench. Instance A uses standard 640x480 timing and
//                is checked line-level from a vector table; instance B uses a
//                tiny raster (15 x 13) so whole-frame behaviour and the frame
//                wrap are reached in a few hundred cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [5:0] col_a, col_b;
    logic [9:0] hpos_a, hpos_b;
    logic [8:0] vpos_a, vpos_b;
    logic       de_a, de_b, fs_a, fs_b, hs_a, hs_b, vs_a, vs_b;
    logic [5:0] rgb_a, rgb_b;

    int checks = 0;
    int errors = 0;
    int ta = 0;
    int tb = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst(rst_a), .color_in(col_a),
        .hpos(hpos_a), .vpos(vpos_a), .display_on(de_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .color_in(col_b),
        .hpos(hpos_b), .vpos(vpos_b), .display_on(de_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b)
    );

    typedef struct {
        int         t;
        logic [5:0] col;
        int         h;
        int         v;
        int         de;
        int         fs;
        int         hs;
        int         vs;
        int         rgb;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
        ta++;
        tb++;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (ta=%0d tb=%0d)", name, act, req, ta, tb);
        end
    endtask

    initial begin
        int hs_low, first_prev_h, prev_h;
        int fs_cnt, vs_low, hsb_low, de_cnt, rgb_cnt;

        // t = cycles since reset release on instance A; col is driven on
        // the cycles leading up to the sample.
        vecs[0]  = '{0,    6'h3F, 0,   0, 1, 1, 1, 1, 0};
        vecs[1]  = '{1,    6'h3F, 1,   0, 1, 0, 1, 1, 6'h3F};
        vecs[2]  = '{639,  6'h3F, 639, 0, 1, 0, 1, 1, 6'h3F};
        vecs[3]  = '{640,  6'h3F, 640, 0, 0, 0, 1, 1, 6'h3F};
        vecs[4]  = '{641,  6'h3F, 641, 0, 0, 0, 1, 1, 0};
        vecs[5]  = '{656,  6'h3F, 656, 0, 0, 0, 1, 1, 0};
        vecs[6]  = '{657,  6'h3F, 657, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{700,  6'h15, 700, 0, 0, 0, 0, 1, 0};
        vecs[8]  = '{701,  6'h2A, 701, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{752,  6'h3F, 752, 0, 0, 0, 0, 1, 0};
        vecs[10] = '{753,  6'h3F, 753, 0, 0, 0, 1, 1, 0};
        vecs[11] = '{799,  6'h3F, 799, 0, 0, 0, 1, 1, 0};
        vecs[12] = '{800,  6'h3F, 0,   1, 1, 0, 1, 1, 0};
        vecs[13] = '{801,  6'h3F, 1,   1, 1, 0, 1, 1, 6'h3F};
        vecs[14] = '{1605, 6'h2A, 5,   2, 1, 0, 1, 1, 6'h2A};

        rst_a = 1'b1;
        rst_b = 1'b1;
        col_a = 6'h3F;
        col_b = 6'h3F;

        // Held reset keeps counters frozen at zero.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_hpos", int'(hpos_a), 0);
            chk("rst_hold_vpos", int'(vpos_a), 0);
        end
        rst_a = 1'b0;
        ta = 0;

        for (int i = 0; i < 15; i++) begin
            col_a = vecs[i].col;
            while (ta < vecs[i].t) step();
            chk($sformatf("vec%0d.hpos", i), int'(hpos_a), vecs[i].h);
            chk($sformatf("vec%0d.vpos", i), int'(vpos_a), vecs[i].v);
            chk($sformatf("vec%0d.de", i),   int'(de_a),   vecs[i].de);
            chk($sformatf("vec%0d.fs", i),   int'(fs_a),   vecs[i].fs);
            chk($sformatf("vec%0d.hs", i),   int'(hs_a),   vecs[i].hs);
            chk($sformatf("vec%0d.vs", i),   int'(vs_a),   vecs[i].vs);
            chk($sformatf("vec%0d.rgb", i),  int'(rgb_a),  vecs[i].rgb);
        end

        // One full line: counter stepping, hsync width and phase.
        col_a = 6'h3F;
        hs_low = 0;
        first_prev_h = -1;
        prev_h = int'(hpos_a);
        for (int i = 0; i < 800; i++) begin
            step();
            chk("line_hpos", int'(hpos_a), ta % 800);
            chk("line_vpos", int'(vpos_a), ta / 800);
            if (hs_a == 1'b0) begin
                if (hs_low == 0) first_prev_h = prev_h;
                hs_low++;
            end
            prev_h = int'(hpos_a);
        end
        chk("hsync_low_width", hs_low, 96);
        chk("hsync_first_low_after", first_prev_h, 656);

        // Instance B still held in reset: counters must remain at zero.
        chk("b_frozen_hpos", int'(hpos_b), 0);
        chk("b_frozen_vpos", int'(vpos_b), 0);

        // Mid-frame reset at hpos=300 of line 3, held for three edges.
        while (ta < 2700) step();
        chk("pre_rst_hpos", int'(hpos_a), 300);
        chk("pre_rst_vpos", int'(vpos_a), 3);
        rst_a = 1'b1;
        step();
        chk("mid_rst_hsync", int'(hs_a), 1);
        chk("mid_rst_vsync", int'(vs_a), 1);
        chk("mid_rst_rgb",   int'(rgb_a), 0);
        chk("mid_rst_hpos",  int'(hpos_a), 0);
        step();
        step();
        chk("mid_rst_hold_hpos", int'(hpos_a), 0);
        rst_a = 1'b0;
        ta = 0;
        chk("rel_hpos", int'(hpos_a), 0);
        chk("rel_vpos", int'(vpos_a), 0);
        chk("rel_fs",   int'(fs_a), 1);
        chk("rel_de",   int'(de_a), 1);
        step();
        chk("rel1_hpos", int'(hpos_a), 1);
        chk("rel1_rgb",  int'(rgb_a), 6'h3F);

        // Small raster: one whole frame (15 x 13 = 195 cycles).
        rst_b = 1'b0;
        tb = 0;
        chk("b0_fs", int'(fs_b), 1);
        chk("b0_de", int'(de_b), 1);
        fs_cnt = 0; vs_low = 0; hsb_low = 0; de_cnt = 0; rgb_cnt = 0;
        for (int i = 1; i <= 195; i++) begin
            step();
            if (fs_b) fs_cnt++;
            if (!vs_b) vs_low++;
            if (!hs_b) hsb_low++;
            if (de_b) de_cnt++;
            if (rgb_b != 6'd0) rgb_cnt++;
            case (tb)
                120: chk("b_vs_before", int'(vs_b), 1);
                121: chk("b_vs_first_low", int'(vs_b), 0);
                150: chk("b_vs_last_low", int'(vs_b), 0);
                151: chk("b_vs_after", int'(vs_b), 1);
                194: begin
                    chk("b_last_hpos", int'(hpos_b), 14);
                    chk("b_last_vpos", int'(vpos_b), 12);
                end
                195: begin
                    chk("b_wrap_hpos", int'(hpos_b), 0);
                    chk("b_wrap_vpos", int'(vpos_b), 0);
                    chk("b_wrap_fs",   int'(fs_b), 1);
                    chk("b_wrap_vs",   int'(vs_b), 1);
                end
                default: ;
            endcase
        end
        chk("b_frame_start_count", fs_cnt, 1);
        chk("b_vsync_low_count", vs_low, 30);
        chk("b_hsync_low_count", hsb_low, 39);
        chk("b_display_count", de_cnt, 48);
        chk("b_rgb_lit_count", rgb_cnt, 48);

        // Reset while vsync is low forces it high on the next edge.
        while (tb < 316) step();
        chk("b_pre_rst_vs", int'(vs_b), 0);
        rst_b = 1'b1;
        step();
        chk("b_rst_vs",   int'(vs_b), 1);
        chk("b_rst_hs",   int'(hs_b), 1);
        chk("b_rst_rgb",  int'(rgb_b), 0);
        chk("b_rst_hpos", int'(hpos_b), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 H_ACTIVE, 640: visible pixels per line.
REQ-002 H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in pixels, giving 800 pixels per line.
REQ-003 V_ACTIVE, 480: visible lines per frame.
REQ-004 V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical porch and sync widths in lines, giving 525 lines per frame.
REQ-005 clk  in  1  pixel clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 color_in  in  6  BBGGRR pixel colour from the painters, sampled for the current hpos/vpos.
REQ-008 hpos  out  10  horizontal counter, range 0..799.
REQ-009 vpos  out  9  low 9 bits of the vertical counter; meaningful only while display_on=1.
REQ-010 display_on  out  1  high when hcount<640 and vcount<480.
REQ-011 frame_start  out  1  one-cycle pulse when hcount=0 and vcount=0.
REQ-012 hsync  out  1  active-low horizontal sync, pipelined one cycle.
REQ-013 vsync  out  1  active-low vertical sync, pipelined one cycle.
REQ-014 rgb  out  6  registered BBGGRR output; blanked to 0 outside the active region.

Function
REQ-015 Horizontal counter: 10-bit hcount increments every clk; after 799 it wraps to 0.
REQ-016 Vertical counter: 10-bit vcount increments only on the cycle hcount wraps 799->0; after 524 it wraps to 0 on that same cycle.
REQ-017 hpos = hcount and vpos = vcount[8:0], combinational from the counter registers, so painters see stage-0 coordinates.
REQ-018 display_on and frame_start are combinational from stage-0 counters.
REQ-019 Stage-0 hsync_raw is 0 for 656 <= hcount <= 751, else 1.
REQ-020 Stage-0 vsync_raw is 0 for 490 <= vcount <= 491, else 1.
REQ-021 Stage 1 registers hsync, vsync, and rgb = display_on ? color_in : 6'b000000, so all three outputs align with one cycle of latency relative to hpos/vpos.
REQ-022 Comparisons use the parameters; no hard-coded constants beyond the derived totals.
REQ-023 Derived totals are H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL likewise; they must fit in 10 bits.
REQ-024 At the line/frame boundary (hcount=799, vcount=524), both counters wrap to 0 on the same edge and frame_start asserts the following cycle.
REQ-025 Any change of color_in outside the active region has no effect on rgb.

Reset
REQ-026 While rst=1 at a clock edge: hcount=0 and vcount=0; hsync=1, vsync=1, rgb=0 (registered).
REQ-027 The first cycle after rst deasserts shows hpos=0, vpos=0, display_on=1, frame_start=1.
REQ-028 Reset asserted mid-frame takes effect on the next edge regardless of counter state; no partial line completes.
REQ-029 A reset held for N cycles keeps the counters frozen at 0 for all N cycles.

Verification
REQ-030 Release reset, run 800 cycles -> hpos steps 0..799 then returns to 0; vpos goes 0->1 exactly at the wrap.
REQ-031 Run 420000 cycles (one frame) -> hsync low for exactly 96 cycles per line, and its first low cycle is one cycle after hpos=656; vsync low for exactly 1600 cycles; exactly 1 frame_start pulse per 420000 cycles.
REQ-032 color_in held at 6'b111111 -> rgb = 6'b111111 on the cycle after hpos=0..639 at vpos=0..479, and rgb=0 on the cycle after hpos=640 and during vpos=480.
REQ-033 color_in toggling at hpos=700 -> rgb remains 0.
REQ-034 Assert rst for 3 cycles at hpos=300, vpos=200 -> next cycle hsync=1, vsync=1, rgb=0; after release, hpos=0, vpos=0, frame_start=1.
REQ-035 Check hpos=799, vcount=524 -> next edge gives hpos=0, vpos=0, frame_start=1; vsync is high.
